// File: rtl/a2_spi_master.sv
// ---------------------------------------------------------------------------
// a2_spi_master
//
// Single-channel SPI master (mode 0) for the TinyFPGA A2 user SPI pins. User
// logic drives it with a word-level start/done handshake. Chip select can be
// held low across words to form bursts. o_pins_oe tells the pin wrapper when
// to drive cs/sclk/mosi; when it is low the wrapper tri-states those pins.
//
// Configuration macro:
//   A2_SPI_LSB_FIRST_EN - when defined, words shift LSB first (transmit and
//                         receive). When undefined, words shift MSB first.
//                         Timing is the same in both builds.
//
// Parameters:
//   CLK_DIV  SCLK half-period in i_clk cycles (>= 1)
//   DATA_W   bits per transfer word (>= 2)
//
// Ports:
//   i_clk      system clock
//   i_reset    synchronous, active-high reset
//   i_start    request one word; accepted only while o_ready=1
//   i_hold_cs  sampled with an accepted start; 1 keeps CS low after the word
//   i_release  in WAIT, ends the burst without another transfer
//   i_tx_data  word to send; sampled with an accepted start
//   o_ready    high in IDLE and WAIT
//   o_busy     high in SETUP, SHIFT and HOLD
//   o_done     one-cycle pulse when o_rx_data is valid
//   o_rx_data  last received word, stable until the next done
//   o_cs_n     to pin18_cs
//   o_sclk     to pin19_sclk
//   o_mosi     to pin4_mosi
//   i_miso     from pin20_miso
//   o_pins_oe  1 = wrapper drives cs/sclk/mosi, 0 = those pins float
// ---------------------------------------------------------------------------
module a2_spi_master #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_hold_cs,
  input  logic              i_release,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_cs_n,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic              o_pins_oe
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t            r_state,   w_state_next;
  logic [CNT_W-1:0]  r_cnt,     w_cnt_next;
  logic [BIT_W-1:0]  r_bit_cnt, w_bit_cnt_next;
  logic [DATA_W-1:0] r_tx_sh,   w_tx_sh_next;
  logic [DATA_W-1:0] r_rx_sh,   w_rx_sh_next;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_next;
  logic              r_hold,    w_hold_next;
  logic              r_sclk,    w_sclk_next;
  logic              r_mosi,    w_mosi_next;
  logic              r_done,    w_done_next;
  logic              r_cs_n,    w_cs_n_next;
  logic              r_ready,   w_ready_next;

  // Bit-order dependent views of the shift registers.
  logic [DATA_W-1:0] w_tx_shifted;
  logic [DATA_W-1:0] w_rx_shifted;
  logic              w_first_bit;
  logic              w_next_bit;

`ifdef A2_SPI_LSB_FIRST_EN
  assign w_tx_shifted = r_tx_sh >> 1;
  assign w_rx_shifted = {i_miso, r_rx_sh[DATA_W-1:1]};
  assign w_first_bit  = i_tx_data[0];
  assign w_next_bit   = w_tx_shifted[0];
`else
  assign w_tx_shifted = r_tx_sh << 1;
  assign w_rx_shifted = {r_rx_sh[DATA_W-2:0], i_miso};
  assign w_first_bit  = i_tx_data[DATA_W-1];
  assign w_next_bit   = w_tx_shifted[DATA_W-1];
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_cnt_next = r_bit_cnt;
    w_tx_sh_next   = r_tx_sh;
    w_rx_sh_next   = r_rx_sh;
    w_rx_data_next = r_rx_data;
    w_hold_next    = r_hold;
    w_sclk_next    = r_sclk;
    w_mosi_next    = r_mosi;
    w_done_next    = 1'b0;

    case (r_state)
      S_IDLE, S_WAIT: begin
        // In WAIT a simultaneous start and release resolve to the start.
        if (i_start) begin
          w_state_next   = S_SETUP;
          w_cnt_next     = '0;
          w_bit_cnt_next = '0;
          w_tx_sh_next   = i_tx_data;
          w_hold_next    = i_hold_cs;
          w_mosi_next    = w_first_bit;
        end else if (r_state == S_WAIT && i_release) begin
          w_state_next = S_HOLD;
          w_cnt_next   = '0;
        end
      end

      S_SETUP: begin
        if (r_cnt == CNT_LAST) begin
          // Leaving SETUP is the first rising SCLK edge.
          w_state_next   = S_SHIFT;
          w_cnt_next     = '0;
          w_sclk_next    = 1'b1;
          w_rx_sh_next   = w_rx_shifted;
          w_bit_cnt_next = r_bit_cnt + 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      S_SHIFT: begin
        if (r_cnt != CNT_LAST) begin
          w_cnt_next = r_cnt + 1'b1;
        end else begin
          w_cnt_next = '0;
          if (r_sclk) begin
            // Falling edge: present the next bit unless the word is complete.
            w_sclk_next = 1'b0;
            if (r_bit_cnt != BIT_LAST) begin
              w_tx_sh_next = w_tx_shifted;
              w_mosi_next  = w_next_bit;
            end
          end else if (r_bit_cnt == BIT_LAST) begin
            // One half-period after the last falling edge the word is done.
            w_done_next    = 1'b1;
            w_rx_data_next = r_rx_sh;
            w_state_next   = r_hold ? S_WAIT : S_HOLD;
          end else begin
            w_sclk_next    = 1'b1;
            w_rx_sh_next   = w_rx_shifted;
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (r_cnt == CNT_LAST) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      default: w_state_next = S_IDLE;
    endcase

    // Pin-level outputs follow the state being entered so they stay registered.
    if (w_state_next != S_SETUP && w_state_next != S_SHIFT) begin
      w_mosi_next = 1'b0;
    end
    w_cs_n_next  = (w_state_next == S_IDLE);
    w_ready_next = (w_state_next == S_IDLE) || (w_state_next == S_WAIT);
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_hold    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_done    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_tx_sh   <= w_tx_sh_next;
      r_rx_sh   <= w_rx_sh_next;
      r_rx_data <= w_rx_data_next;
      r_hold    <= w_hold_next;
      r_sclk    <= w_sclk_next;
      r_mosi    <= w_mosi_next;
      r_done    <= w_done_next;
      r_cs_n    <= w_cs_n_next;
      r_ready   <= w_ready_next;
    end
  end

  assign o_ready   = r_ready;
  assign o_busy    = ~r_ready;
  assign o_done    = r_done;
  assign o_rx_data = r_rx_data;
  assign o_cs_n    = r_cs_n;
  assign o_sclk    = r_sclk;
  assign o_mosi    = r_mosi;
  assign o_pins_oe = ~r_cs_n;

endmodule

// File: tb/tb_a2_spi_master.sv
// ---------------------------------------------------------------------------
// tb_a2_spi_master
//
// Directed bench for a2_spi_master with CLK_DIV=4, DATA_W=8 and MISO looped
// back to MOSI. Every accepted word is pushed to a scoreboard queue when it
// is issued; each done pulse pops one entry and compares rx_data and the word
// seen on MOSI at the SCLK rising edges.
// ---------------------------------------------------------------------------
module tb_a2_spi_master;

  localparam int CLK_DIV = 4;
  localparam int DATA_W  = 8;
  localparam int T_DONE  = CLK_DIV * (1 + 2 * DATA_W);   // 68
  localparam int T_CSUP  = CLK_DIV * (2 + 2 * DATA_W);   // 72

  logic              clk;
  logic              reset;
  logic              start;
  logic              hold_cs;
  logic              release_req;
  logic [DATA_W-1:0] tx_data;
  logic              ready;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              cs_n;
  logic              sclk;
  logic              mosi;
  logic              pins_oe;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] sb_q[$];
  logic [DATA_W-1:0] sb_exp;
  logic [DATA_W-1:0] mosi_cap = '0;
  logic              prev_sclk = 1'b0;
  logic              cs_high_seen = 1'b0;
  logic              oe_seen = 1'b0;
  int                n_rise = 0;
  int                n_done = 0;
  int                done_base;

  a2_spi_master #(
    .CLK_DIV(CLK_DIV),
    .DATA_W (DATA_W)
  ) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_start  (start),
    .i_hold_cs(hold_cs),
    .i_release(release_req),
    .i_tx_data(tx_data),
    .o_ready  (ready),
    .o_busy   (busy),
    .o_done   (done),
    .o_rx_data(rx_data),
    .o_cs_n   (cs_n),
    .o_sclk   (sclk),
    .o_mosi   (mosi),
    .i_miso   (mosi),
    .o_pins_oe(pins_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue a start that is accepted at the next edge (edge 0); returns after edge 0.
  task automatic go_start(input logic [DATA_W-1:0] d, input logic hc);
    start   = 1'b1;
    tx_data = d;
    hold_cs = hc;
    sb_q.push_back(d);
    step(1);
    start   = 1'b0;
    hold_cs = 1'b0;
  endtask

  // Monitor: counts SCLK rises, captures MOSI, tracks CS, scores done pulses.
  always @(posedge clk) begin
    #1;
    if (sclk && !prev_sclk) begin
      n_rise++;
`ifdef A2_SPI_LSB_FIRST_EN
      mosi_cap = {mosi, mosi_cap[DATA_W-1:1]};
`else
      mosi_cap = {mosi_cap[DATA_W-2:0], mosi};
`endif
    end
    prev_sclk = sclk;
    if (cs_n) cs_high_seen = 1'b1;
    if (done) begin
      n_done++;
      check("done_has_request", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        sb_exp = sb_q.pop_front();
        check("sb_rx_data", 32'(rx_data), 32'(sb_exp));
        check("sb_mosi_word", 32'(mosi_cap), 32'(sb_exp));
      end
    end
  end

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    hold_cs     = 1'b0;
    release_req = 1'b0;
    tx_data     = '0;

    // Reset values, then 100 idle cycles with the pins released.
    step(3);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_oe", 32'(pins_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rx", 32'(rx_data), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (pins_oe) oe_seen = 1'b1;
    end
    check("idle_oe_never_high", 32'(oe_seen), 32'd0);
    check("idle_cs_n", 32'(cs_n), 32'd1);

    // Single word A5 with a start at edge 20 that must be ignored.
    n_rise    = 0;
    done_base = n_done;
    go_start(8'hA5, 1'b0);
    check("w1_cs_n_fall", 32'(cs_n), 32'd0);
    check("w1_busy", 32'(busy), 32'd1);
    check("w1_ready", 32'(ready), 32'd0);
    check("w1_oe", 32'(pins_oe), 32'd1);
    check("w1_first_bit", 32'(mosi), 32'd1);
    step(CLK_DIV - 1);
    check("w1_sclk_before_rise", 32'(sclk), 32'd0);
    step(1);
    check("w1_sclk_first_rise", 32'(sclk), 32'd1);
    step(15);
    start   = 1'b1;
    tx_data = 8'h3C;
    step(1);
    start   = 1'b0;
    check("w1_busy_ignores_start", 32'(busy), 32'd1);
    step(T_DONE - 1 - 20);
    check("w1_done_early", 32'(done), 32'd0);
    step(1);
    check("w1_done", 32'(done), 32'd1);
    check("w1_rx", 32'(rx_data), 32'hA5);
    check("w1_busy_hold", 32'(busy), 32'd1);
    step(1);
    check("w1_done_one_cycle", 32'(done), 32'd0);
    step(T_CSUP - T_DONE - 2);
    check("w1_cs_low_before_end", 32'(cs_n), 32'd0);
    step(1);
    check("w1_cs_high", 32'(cs_n), 32'd1);
    check("w1_oe_low", 32'(pins_oe), 32'd0);
    check("w1_ready_first_idle", 32'(ready), 32'd1);
    check("w1_rises", 32'(n_rise), 32'd8);
    check("w1_single_done", 32'(n_done - done_base), 32'd1);
    step(10);
    check("w1_oe_stays_low", 32'(pins_oe), 32'd0);

    // Burst: 01 with hold_cs=1, then 80 from WAIT.
    done_base = n_done;
    go_start(8'h01, 1'b1);
    cs_high_seen = 1'b0;
    step(T_DONE);
    check("b1_done", 32'(done), 32'd1);
    check("b1_ready_wait", 32'(ready), 32'd1);
    check("b1_busy_wait", 32'(busy), 32'd0);
    step(1);
    check("b1_wait_cs_n", 32'(cs_n), 32'd0);
    check("b1_wait_oe", 32'(pins_oe), 32'd1);
    check("b1_wait_sclk", 32'(sclk), 32'd0);
    check("b1_wait_mosi", 32'(mosi), 32'd0);
    step(2);
    go_start(8'h80, 1'b0);
    step(T_DONE);
    check("b2_done", 32'(done), 32'd1);
    step(CLK_DIV - 1);
    check("b2_cs_low", 32'(cs_n), 32'd0);
    check("b_cs_never_high", 32'(cs_high_seen), 32'd0);
    step(1);
    check("b2_cs_high", 32'(cs_n), 32'd1);
    check("b_two_dones", 32'(n_done - done_base), 32'd2);

    // WAIT with start and release together, then release alone.
    step(4);
    go_start(8'h5A, 1'b1);
    cs_high_seen = 1'b0;
    step(T_DONE + 1);
    start       = 1'b1;
    release_req = 1'b1;
    tx_data     = 8'hC3;
    hold_cs     = 1'b1;
    sb_q.push_back(8'hC3);
    step(1);
    start       = 1'b0;
    release_req = 1'b0;
    hold_cs     = 1'b0;
    check("sr_start_wins_busy", 32'(busy), 32'd1);
    check("sr_cs_low", 32'(cs_n), 32'd0);
    step(T_DONE);
    check("sr_done", 32'(done), 32'd1);
    step(2);
    release_req = 1'b1;
    step(1);
    release_req = 1'b0;
    check("rel_hold_cs_low", 32'(cs_n), 32'd0);
    check("rel_busy", 32'(busy), 32'd1);
    step(CLK_DIV - 1);
    check("rel_cs_low_last", 32'(cs_n), 32'd0);
    check("sr_cs_never_high", 32'(cs_high_seen), 32'd0);
    step(1);
    check("rel_cs_high", 32'(cs_n), 32'd1);
    check("rel_oe_low", 32'(pins_oe), 32'd0);
    check("rel_rx_kept", 32'(rx_data), 32'hC3);

    // Reset at edge 30 of a transfer aborts it.
    step(5);
    done_base = n_done;
    go_start(8'hFF, 1'b0);
    step(29);
    reset = 1'b1;
    step(1);
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_oe", 32'(pins_oe), 32'd0);
    check("abort_rx", 32'(rx_data), 32'd0);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    reset = 1'b0;
    sb_q.delete();
    step(80);
    check("abort_no_done", 32'(n_done - done_base), 32'd0);
    check("abort_idle_cs", 32'(cs_n), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
